demux_4x1_top: RTL and testbench
================================

DEMUX_4X1_TOP -- requirements
Module: demux_4x1_top

Interface
REQ-001 The block SHALL have parameter DATA_W, default 1, giving the width of one data channel in bits.
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the width of each route counter; it is used only when DEMUX_4X1_STATUS_EN is defined.
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n_i, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have port en_i, input, 1 bit: routing enable.
REQ-006 The block SHALL have port data_in_i, input, DATA_W bits: the data to route.
REQ-007 The block SHALL have port sel_i, input, 2 bits: destination channel index, 0 to 3.
REQ-008 The block SHALL have port data_out_o, output, 4*DATA_W bits: channel k occupies bits [k*DATA_W +: DATA_W].
REQ-009 The block SHALL have port clr_cnt_i, input, 1 bit, present only with DEMUX_4X1_STATUS_EN: synchronous clear of all route counters.
REQ-010 The block SHALL have port route_cnt_o, output, 4*CNT_W bits, present only with DEMUX_4X1_STATUS_EN: channel k's counter at bits [k*CNT_W +: CNT_W].

Function
REQ-011 When en_i=1, the rising edge SHALL load channel sel_i of data_out_o with data_in_i and all other channels with 0.
- With DATA_W=1 and data_in_i=1, data_out_o is one-hot.
REQ-012 When en_i=0, the rising edge SHALL load all of data_out_o with 0.
REQ-013 Latency SHALL be exactly one clock from inputs to data_out_o; data_out_o SHALL be driven directly from flops, with no combinational path from any input.
REQ-014 A sel_i change SHALL take effect on the next edge with no intermediate glitch cycle, and back-to-back sel_i changes every cycle SHALL each be honoured.
REQ-015 When data_in_i=0, the selected channel SHALL output 0, which is indistinguishable from an unselected channel.
REQ-016 In simulation, when sel_i contains X/Z and en_i=1, all of data_out_o SHALL load 0.

Reset
REQ-017 When rst_n_i=0 at a rising edge, data_out_o SHALL become all zeros and every route counter SHALL become 0.
REQ-018 Reset SHALL take priority over en_i, sel_i and clr_cnt_i, including when asserted mid-stream.
REQ-019 On the first edge after rst_n_i returns to 1, normal routing per REQ-011/REQ-012 SHALL resume.

Configuration
REQ-020 With macro DEMUX_4X1_STATUS_EN defined, the block SHALL keep four CNT_W-bit route counters.
- Counter k increments on each edge where en_i=1 and sel_i=k.
- Counters saturate at 2^CNT_W-1.
- clr_cnt_i=1 zeroes all counters, and the clear takes priority over an increment in the same cycle.
REQ-021 With DEMUX_4X1_STATUS_EN undefined, the block SHALL contain no counter logic, and ports clr_cnt_i and route_cnt_o SHALL NOT exist; routing behaviour SHALL be identical in both builds.

Structure
REQ-022 A shared package demux_4x1_pkg SHALL hold the following, and the block SHALL import it:
- constant NUM_CH=4;
- constant SEL_W=2;
- typedef sel_t (logic [SEL_W-1:0]).
REQ-023 A sub-module demux_4x1_cnt SHALL implement one saturating, clearable, synchronously reset counter.
- Ports: clk_i, rst_n_i, clr_i, inc_i, cnt_o.
- The block instantiates it NUM_CH times under DEMUX_4X1_STATUS_EN.

Verification
REQ-024 The bench SHALL cover routing: DATA_W=1, en_i=1, data_in_i=1, sel_i stepping 00,01,10,11 one per cycle -> data_out_o = 0001, 0010, 0100, 1000, each one cycle after its sel_i.
REQ-025 The bench SHALL cover enable: en_i=0, data_in_i=1, sel_i=10 -> data_out_o=0000 on the next edge; en_i=1 -> 0100 on the following edge.
REQ-026 The bench SHALL cover reset mid-stream: data_out_o=1000, then rst_n_i=0 for one edge -> data_out_o=0000 at that edge; no change between edges; routing resumes on the first edge after release.
REQ-027 The bench SHALL cover wide data: DATA_W=8, data_in_i=8'hA5, sel_i=01 -> data_out_o=32'h0000_A500.
REQ-028 The bench SHALL cover counters, with DEMUX_4X1_STATUS_EN and CNT_W=2: five edges with sel_i=11, en_i=1 -> counter 3 reads 3 (saturated) and the others read 0; clr_cnt_i=1 with an increment pending -> all counters 0.

Source files
------------

// File: rtl/demux_4x1_pkg.sv
// Shared constants and types for the 1-to-4 registered demultiplexer.
package demux_4x1_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned SEL_W  = 2;

  typedef logic [SEL_W-1:0] sel_t;

endpackage

// File: rtl/demux_4x1_if.sv
// Bundle of the demux routing signals; the route counter fields exist only
// when DEMUX_4X1_STATUS_EN is defined.
interface demux_4x1_if
  import demux_4x1_pkg::*;
#(
  parameter int unsigned DATA_W = 1,
  parameter int unsigned CNT_W  = 8
) (
  input logic clk_i
);

  logic                     en;
  logic [DATA_W-1:0]        data_in;
  sel_t                     sel;
  logic [NUM_CH*DATA_W-1:0] data_out;
`ifdef DEMUX_4X1_STATUS_EN
  logic                     clr_cnt;
  logic [NUM_CH*CNT_W-1:0]  route_cnt;
`endif

  modport master (
    input  clk_i,
    output en,
    output data_in,
    output sel,
`ifdef DEMUX_4X1_STATUS_EN
    output clr_cnt,
    input  route_cnt,
`endif
    input  data_out
  );

  modport slave (
    input  clk_i,
    input  en,
    input  data_in,
    input  sel,
`ifdef DEMUX_4X1_STATUS_EN
    input  clr_cnt,
    output route_cnt,
`endif
    output data_out
  );

endinterface

// File: rtl/demux_4x1_cnt.sv
// Saturating route counter with synchronous clear and synchronous active-low reset.
module demux_4x1_cnt #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_d, cnt_q;

  // Clear wins over an increment in the same cycle; stop at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/demux_4x1_top.sv
// Registered 1-to-4 demultiplexer. Define DEMUX_4X1_STATUS_EN to add per-channel
// saturating route counters and their clear input.
module demux_4x1_top
  import demux_4x1_pkg::*;
#(
  parameter int unsigned DATA_W = 1,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     en_i,
  input  logic [DATA_W-1:0]        data_in_i,
  input  sel_t                     sel_i,
`ifdef DEMUX_4X1_STATUS_EN
  input  logic                     clr_cnt_i,
  output logic [NUM_CH*CNT_W-1:0]  route_cnt_o,
`endif
  output logic [NUM_CH*DATA_W-1:0] data_out_o
);

  logic [NUM_CH-1:0]        route_hit;
  logic [NUM_CH*DATA_W-1:0] data_out_d, data_out_q;

  // 'if' rather than '?:' so an unknown select resolves to zero, not X.
  always_comb begin
    route_hit  = '0;
    data_out_d = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (en_i && (sel_i == sel_t'(k))) begin
        route_hit[k]                   = 1'b1;
        data_out_d[k*DATA_W +: DATA_W] = data_in_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      data_out_q <= '0;
    end else begin
      data_out_q <= data_out_d;
    end
  end

  assign data_out_o = data_out_q;

`ifdef DEMUX_4X1_STATUS_EN
  for (genvar k = 0; k < NUM_CH; k++) begin : g_cnt
    demux_4x1_cnt #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .clr_i   (clr_cnt_i),
      .inc_i   (route_hit[k]),
      .cnt_o   (route_cnt_o[k*CNT_W +: CNT_W])
    );
  end
`endif

endmodule

// File: tb/tb_demux_4x1_top.sv
// Self-checking bench: directed routing/enable/reset/counter scenarios, then random traffic
// against an arithmetic reference model. Counter checks need DEMUX_4X1_STATUS_EN.
module tb_demux_4x1_top;

  logic clk;
  logic rst_n;

  int unsigned checks = 0;
  int unsigned passes = 0;

  logic [3:0]  exp_a;
  logic [31:0] exp_b;
  int unsigned mcnt [4];

  demux_4x1_if #(.DATA_W(1), .CNT_W(2)) if_a (.clk_i(clk));
  demux_4x1_if #(.DATA_W(8), .CNT_W(8)) if_b (.clk_i(clk));

  demux_4x1_top #(
    .DATA_W (1),
    .CNT_W  (2)
  ) u_dut_a (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .en_i        (if_a.en),
    .data_in_i   (if_a.data_in),
    .sel_i       (if_a.sel),
`ifdef DEMUX_4X1_STATUS_EN
    .clr_cnt_i   (if_a.clr_cnt),
    .route_cnt_o (if_a.route_cnt),
`endif
    .data_out_o  (if_a.data_out)
  );

  demux_4x1_top #(
    .DATA_W (8),
    .CNT_W  (8)
  ) u_dut_b (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .en_i        (if_b.en),
    .data_in_i   (if_b.data_in),
    .sel_i       (if_b.sel),
`ifdef DEMUX_4X1_STATUS_EN
    .clr_cnt_i   (if_b.clr_cnt),
    .route_cnt_o (if_b.route_cnt),
`endif
    .data_out_o  (if_b.data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Both instances share control; channel k carries the data iff enabled and selected.
  task automatic drive(input bit en, input logic [1:0] sel, input bit da, input logic [7:0] db,
                       input bit clr);
    if_a.en      = en;
    if_a.sel     = sel;
    if_a.data_in = da;
    if_b.en      = en;
    if_b.sel     = sel;
    if_b.data_in = db;
`ifdef DEMUX_4X1_STATUS_EN
    if_a.clr_cnt = clr;
    if_b.clr_cnt = clr;
`else
    if (clr) begin end
`endif
  endtask

  // One clock edge: advance the reference model, then compare just after the edge.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      exp_a = '0;
      exp_b = '0;
      foreach (mcnt[k]) mcnt[k] = 0;
    end else begin
      exp_a = if_a.en ? (4'(if_a.data_in) << if_a.sel) : 4'h0;
      exp_b = if_b.en ? (32'(if_b.data_in) << (8 * int'(if_b.sel))) : 32'h0;
`ifdef DEMUX_4X1_STATUS_EN
      if (if_a.clr_cnt) begin
        foreach (mcnt[k]) mcnt[k] = 0;
      end else if (if_a.en && mcnt[if_a.sel] < 3) begin
        mcnt[if_a.sel] = mcnt[if_a.sel] + 1;
      end
`endif
    end
    #1;
    check("model_out_a", 32'(if_a.data_out), 32'(exp_a));
    check("model_out_b", if_b.data_out, exp_b);
`ifdef DEMUX_4X1_STATUS_EN
    begin
      logic [7:0] exp_cnt;
      for (int k = 0; k < 4; k++) exp_cnt[k*2 +: 2] = 2'(mcnt[k]);
      check("model_cnt_a", 32'(if_a.route_cnt), 32'(exp_cnt));
    end
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b1, 2'd3, 1'b1, 8'hFF, 1'b0);
    tick();
    check("reset_out_a", 32'(if_a.data_out), 32'h0);
    check("reset_out_b", if_b.data_out, 32'h0);
`ifdef DEMUX_4X1_STATUS_EN
    check("reset_cnt_a", 32'(if_a.route_cnt), 32'h0);
`endif

    // Routing walk: one-hot output one cycle after each select.
    rst_n = 1'b1;
    for (int s = 0; s < 4; s++) begin
      drive(1'b1, 2'(s), 1'b1, 8'h00, 1'b0);
      tick();
      check("route_walk", 32'(if_a.data_out), 32'(4'b0001 << s));
    end

    // Enable low forces zeros; re-enable routes again.
    drive(1'b0, 2'd2, 1'b1, 8'h00, 1'b0);
    tick();
    check("enable_off", 32'(if_a.data_out), 32'h0);
    drive(1'b1, 2'd2, 1'b1, 8'h00, 1'b0);
    tick();
    check("enable_on", 32'(if_a.data_out), 32'h4);

    // Zero data on the selected channel looks like no route.
    drive(1'b1, 2'd1, 1'b0, 8'h00, 1'b0);
    tick();
    check("zero_data", 32'(if_a.data_out), 32'h0);

    // Reset mid-stream overrides enable/select/clear.
    drive(1'b1, 2'd3, 1'b1, 8'h00, 1'b0);
    tick();
    check("pre_reset", 32'(if_a.data_out), 32'h8);
    rst_n = 1'b0;
    drive(1'b1, 2'd3, 1'b1, 8'h00, 1'b1);
    tick();
    check("mid_reset", 32'(if_a.data_out), 32'h0);
    #3;
    check("reset_hold", 32'(if_a.data_out), 32'h0);
    rst_n = 1'b1;
    drive(1'b1, 2'd1, 1'b1, 8'h00, 1'b0);
    tick();
    check("reset_resume", 32'(if_a.data_out), 32'h2);

    // Wide data lands in channel 1's byte.
    drive(1'b1, 2'd1, 1'b0, 8'hA5, 1'b0);
    tick();
    check("wide_data", if_b.data_out, 32'h0000_A500);

`ifdef DEMUX_4X1_STATUS_EN
    drive(1'b0, 2'd0, 1'b0, 8'h00, 1'b1);
    tick();
    check("cnt_clear", 32'(if_a.route_cnt), 32'h0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 2'd3, 1'b1, 8'h00, 1'b0);
      tick();
    end
    check("cnt_saturate", 32'(if_a.route_cnt), 32'hC0);
    drive(1'b1, 2'd3, 1'b1, 8'h00, 1'b1);
    tick();
    check("cnt_clr_prio", 32'(if_a.route_cnt), 32'h0);
`endif

    // Random traffic, including occasional reset and clear.
    for (int i = 0; i < 300; i++) begin
      rst_n = ($urandom_range(0, 24) != 0);
      drive(1'($urandom_range(0, 3) != 0), 2'($urandom), 1'($urandom), 8'($urandom),
            ($urandom_range(0, 15) == 0));
      tick();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
